wb_stage: RTL and testbench

- Writeback stage of the RV32I core. It sits directly upstream of the register file and drives that file's single write port.
- Registers the MEM-stage result and selects the writeback source (ALU, load, PC+4).
- Aligns and sign- or zero-extends load data, and blocks misaligned or illegal loads.
- Exports a bypass copy of the write-port value for ID-stage forwarding, and keeps a 64-bit retired-instruction counter.

---
 rtl/rv32_pkg.sv | 16 +
 rtl/load_align.sv | 50 +++++
 rtl/wb_stage.sv | 106 ++++++++++
 tb/tb_wb_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: writeback source encoding and load funct3 codes.
package rv32_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'b00,
      WB_LOAD = 2'b01,
      WB_PC4  = 2'b10
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: picks byte/half/word from an aligned memory word,
// extends it, and flags illegal funct3 or misaligned addresses.
module load_align
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      lsb,
   input  logic [XLEN-1:0] word,
   output logic [XLEN-1:0] data,
   output logic            err
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lsb)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = lsb[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data = '0;
      err  = 1'b0;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH: begin
            data = {{(XLEN-16){half_sel[15]}}, half_sel};
            err  = lsb[0];
         end
         F3_LHU: begin
            data = {{(XLEN-16){1'b0}}, half_sel};
            err  = lsb[0];
         end
         F3_LW: begin
            data = word;
            err  = (lsb != 2'd0);
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registers the MEM result, selects the writeback source,
// drives the regfile write port plus its bypass copy, and counts retirements.
module wb_stage
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 64
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   input  logic             i_flush,
   input  logic [4:0]       i_rd_addr,
   input  logic             i_rd_wren,
   input  logic [1:0]       i_wb_sel,
   input  logic [XLEN-1:0]  i_alu_data,
   input  logic [XLEN-1:0]  i_pc4,
   input  logic [XLEN-1:0]  i_ld_data,
   input  logic [2:0]       i_ld_funct3,
   input  logic [1:0]       i_addr_lsb,
   output logic [4:0]       o_rd_addr,
   output logic             o_rd_wren,
   output logic [XLEN-1:0]  o_rd_data,
   output logic             o_fwd_valid,
   output logic [4:0]       o_fwd_addr,
   output logic [XLEN-1:0]  o_fwd_data,
   output logic             o_ld_err,
   output logic [CNT_W-1:0] o_instret
);

   logic             stage_valid;
   logic [4:0]       rd_addr_q;
   logic             rd_wren_q;
   logic [1:0]       wb_sel_q;
   logic [XLEN-1:0]  alu_q;
   logic [XLEN-1:0]  pc4_q;
   logic [XLEN-1:0]  ld_word_q;
   logic [2:0]       funct3_q;
   logic [1:0]       lsb_q;
   logic [CNT_W-1:0] instret_q;

   logic [XLEN-1:0]  align_data;
   logic             align_err;
   logic             ld_err;
   logic             wren;
   logic [XLEN-1:0]  wr_data;

   // Data fields are captured every cycle; only the valid bit gates side effects.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stage_valid <= 1'b0;
         rd_addr_q   <= '0;
         rd_wren_q   <= 1'b0;
         wb_sel_q    <= '0;
         alu_q       <= '0;
         pc4_q       <= '0;
         ld_word_q   <= '0;
         funct3_q    <= '0;
         lsb_q       <= '0;
         instret_q   <= '0;
      end else begin
         stage_valid <= i_valid & ~i_flush;
         rd_addr_q   <= i_rd_addr;
         rd_wren_q   <= i_rd_wren;
         wb_sel_q    <= i_wb_sel;
         alu_q       <= i_alu_data;
         pc4_q       <= i_pc4;
         ld_word_q   <= i_ld_data;
         funct3_q    <= i_ld_funct3;
         lsb_q       <= i_addr_lsb;
         if (stage_valid && !ld_err)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   load_align #(
      .XLEN(XLEN)
   ) u_load_align (
      .funct3 (funct3_q),
      .lsb    (lsb_q),
      .word   (ld_word_q),
      .data   (align_data),
      .err    (align_err)
   );

   always_comb begin
      wr_data = alu_q;
      case (wb_sel_q)
         WB_LOAD: wr_data = align_data;
         WB_PC4:  wr_data = pc4_q;
         default: wr_data = alu_q;
      endcase
      ld_err = stage_valid && (wb_sel_q == WB_LOAD) && align_err;
      wren   = stage_valid && rd_wren_q && (rd_addr_q != 5'd0) && !ld_err;
   end

   assign o_rd_addr   = rd_addr_q;
   assign o_rd_wren   = wren;
   assign o_rd_data   = wr_data;
   assign o_fwd_valid = wren;
   assign o_fwd_addr  = rd_addr_q;
   assign o_fwd_data  = wr_data;
   assign o_ld_err    = ld_err;
   assign o_instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expectations from a reference
// model; a monitor pops and compares one entry per cycle.
module tb_wb_stage;
   import rv32_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid, i_flush, i_rd_wren;
   logic [4:0]  i_rd_addr;
   logic [1:0]  i_wb_sel;
   logic [31:0] i_alu_data, i_pc4, i_ld_data;
   logic [2:0]  i_ld_funct3;
   logic [1:0]  i_addr_lsb;

   logic [4:0]  o_rd_addr, o_fwd_addr;
   logic        o_rd_wren, o_fwd_valid, o_ld_err;
   logic [31:0] o_rd_data, o_fwd_data;
   logic [63:0] o_instret;

   logic [4:0]  s_rd_addr, s_fwd_addr;
   logic        s_rd_wren, s_fwd_valid, s_ld_err;
   logic [31:0] s_rd_data, s_fwd_data;
   logic [3:0]  s_instret;

   always #5 i_clk = ~i_clk;

   wb_stage #(.XLEN(32), .CNT_W(64)) u_dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
      .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren), .i_wb_sel(i_wb_sel),
      .i_alu_data(i_alu_data), .i_pc4(i_pc4), .i_ld_data(i_ld_data),
      .i_ld_funct3(i_ld_funct3), .i_addr_lsb(i_addr_lsb),
      .o_rd_addr(o_rd_addr), .o_rd_wren(o_rd_wren), .o_rd_data(o_rd_data),
      .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_data(o_fwd_data),
      .o_ld_err(o_ld_err), .o_instret(o_instret)
   );

   // Narrow-counter instance exercises counter wrap-around in a short run.
   wb_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
      .i_rd_addr(i_rd_addr), .i_rd_wren(i_rd_wren), .i_wb_sel(i_wb_sel),
      .i_alu_data(i_alu_data), .i_pc4(i_pc4), .i_ld_data(i_ld_data),
      .i_ld_funct3(i_ld_funct3), .i_addr_lsb(i_addr_lsb),
      .o_rd_addr(s_rd_addr), .o_rd_wren(s_rd_wren), .o_rd_data(s_rd_data),
      .o_fwd_valid(s_fwd_valid), .o_fwd_addr(s_fwd_addr), .o_fwd_data(s_fwd_data),
      .o_ld_err(s_ld_err), .o_instret(s_instret)
   );

   typedef struct packed {
      logic        wren;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        data_chk;
      logic        ld_err;
      logic [63:0] instret;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [63:0] m_instret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                            input logic [31:0] word);
      logic [31:0] v;
      if (f3[1:0] == 2'd0) begin
         v = (word >> (8 * lsb)) & 32'h0000_00FF;
         if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (f3[1:0] == 2'd1) begin
         v = (word >> (16 * lsb[1])) & 32'h0000_FFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = word;
      end
      return v;
   endfunction

   function automatic logic bad_load(input logic [2:0] f3, input logic [1:0] lsb);
      int size;
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
      size = 1 << f3[1:0];
      return (int'(lsb) % size) != 0;
   endfunction

   task automatic drive(input logic v, input logic fl, input logic [4:0] rd, input logic we,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] word, input logic [2:0] f3, input logic [1:0] lsb);
      exp_t e;
      logic sv, bad, is_ld;
      @(negedge i_clk);
      i_reset = 1'b0;
      i_valid = v; i_flush = fl; i_rd_addr = rd; i_rd_wren = we; i_wb_sel = sel;
      i_alu_data = alu; i_pc4 = pc4; i_ld_data = word; i_ld_funct3 = f3; i_addr_lsb = lsb;
      sv    = v && !fl;
      is_ld = (sel == 2'b01);
      bad   = is_ld && bad_load(f3, lsb);
      e.addr     = rd;
      e.data     = is_ld ? ref_load(f3, lsb, word) : (sel == 2'b10) ? pc4 : alu;
      e.data_chk = !bad;
      e.ld_err   = sv && bad;
      e.wren     = sv && we && (rd != 5'd0) && !bad;
      e.instret  = m_instret;
      sb.push_back(e);
      if (sv && !bad) m_instret = m_instret + 64'd1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge i_clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wren", {63'd0, o_rd_wren}, {63'd0, e.wren});
            chk("addr", {59'd0, o_rd_addr}, {59'd0, e.addr});
            if (e.data_chk) chk("data", {32'd0, o_rd_data}, {32'd0, e.data});
            chk("fwd_valid", {63'd0, o_fwd_valid}, {63'd0, e.wren});
            chk("fwd_addr", {59'd0, o_fwd_addr}, {59'd0, e.addr});
            if (e.data_chk) chk("fwd_data", {32'd0, o_fwd_data}, {32'd0, e.data});
            chk("ld_err", {63'd0, o_ld_err}, {63'd0, e.ld_err});
            chk("instret", o_instret, e.instret);
            chk("n_wren", {63'd0, s_rd_wren}, {63'd0, e.wren});
            chk("n_addr", {59'd0, s_rd_addr}, {59'd0, e.addr});
            if (e.data_chk) chk("n_data", {32'd0, s_rd_data}, {32'd0, e.data});
            chk("n_fwd_valid", {63'd0, s_fwd_valid}, {63'd0, e.wren});
            chk("n_fwd_addr", {59'd0, s_fwd_addr}, {59'd0, e.addr});
            if (e.data_chk) chk("n_fwd_data", {32'd0, s_fwd_data}, {32'd0, e.data});
            chk("n_ld_err", {63'd0, s_ld_err}, {63'd0, e.ld_err});
            chk("n_instret_wrap", {60'd0, s_instret}, {60'd0, e.instret[3:0]});
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   localparam logic [31:0] WORD = 32'h80F0_7F81;

   initial begin : stim
      m_instret   = '0;
      i_reset     = 1'b1;
      i_valid     = 1'b1; i_flush = 1'b0; i_rd_addr = 5'd5; i_rd_wren = 1'b1;
      i_wb_sel    = 2'b00; i_alu_data = 32'h1234_5678; i_pc4 = 32'h4;
      i_ld_data   = WORD; i_ld_funct3 = 3'b010; i_addr_lsb = 2'd0;

      repeat (3) begin
         @(negedge i_clk);
         chk("rst_wren", {63'd0, o_rd_wren}, 64'd0);
         chk("rst_addr", {59'd0, o_rd_addr}, 64'd0);
         chk("rst_data", {32'd0, o_rd_data}, 64'd0);
         chk("rst_fwd", {31'd0, o_fwd_valid, o_fwd_data}, 64'd0);
         chk("rst_ld_err", {63'd0, o_ld_err}, 64'd0);
         chk("rst_instret", o_instret, 64'd0);
      end

      // ALU, PC4 and reserved-select paths
      drive(1, 0, 5'd5, 1, 2'b00, 32'hDEAD_BEEF, 32'h100, WORD, 3'b000, 2'd0);
      drive(1, 0, 5'd6, 1, 2'b10, 32'h1, 32'h0000_1004, WORD, 3'b000, 2'd0);
      drive(1, 0, 5'd7, 1, 2'b11, 32'hCAFE_F00D, 32'h8, WORD, 3'b000, 2'd0);
      // loads
      drive(1, 0, 5'd8,  1, 2'b01, 32'h0, 32'h0, WORD, F3_LB,  2'd0);
      drive(1, 0, 5'd9,  1, 2'b01, 32'h0, 32'h0, WORD, F3_LBU, 2'd3);
      drive(1, 0, 5'd10, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LH,  2'd2);
      drive(1, 0, 5'd11, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LHU, 2'd0);
      drive(1, 0, 5'd12, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LW,  2'd0);
      // faulting loads, separated by bubbles
      drive(1, 0, 5'd13, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LW,  2'd2);
      drive(0, 0, 5'd0,  0, 2'b00, 32'h0, 32'h0, WORD, F3_LB,  2'd0);
      drive(1, 0, 5'd14, 1, 2'b01, 32'h0, 32'h0, WORD, 3'b011, 2'd0);
      drive(1, 0, 5'd15, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LH,  2'd1);
      drive(0, 0, 5'd0,  0, 2'b00, 32'h0, 32'h0, WORD, F3_LB,  2'd0);
      // rd=0, non-writing, flush
      drive(1, 0, 5'd0,  1, 2'b00, 32'h5555_AAAA, 32'h0, WORD, F3_LB, 2'd0);
      drive(1, 0, 5'd16, 0, 2'b00, 32'h7777_0000, 32'h0, WORD, F3_LB, 2'd0);
      drive(1, 1, 5'd17, 1, 2'b00, 32'h1111_2222, 32'h0, WORD, F3_LB, 2'd0);
      drive(1, 1, 5'd18, 1, 2'b01, 32'h0, 32'h0, WORD, F3_LW, 2'd1);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
               5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom),
               $urandom, $urandom, $urandom, 3'($urandom), 2'($urandom));
      end

      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 5'($urandom_range(1, 31)), 1, 2'b00, $urandom, 32'h0, WORD, F3_LB, 2'd0);
      end

      repeat (2) @(posedge i_clk);
      #2;
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);

      // asynchronous reset while an instruction occupies the stage
      @(negedge i_clk);
      i_valid = 1'b1; i_flush = 1'b0; i_rd_addr = 5'd3; i_rd_wren = 1'b1; i_wb_sel = 2'b00;
      i_alu_data = 32'hABCD_0123;
      @(posedge i_clk);
      #1;
      chk("inflight_wren", {63'd0, o_rd_wren}, 64'd1);
      #1 i_reset = 1'b1;
      #1;
      chk("midrst_wren", {63'd0, o_rd_wren}, 64'd0);
      chk("midrst_data", {32'd0, o_rd_data}, 64'd0);
      chk("midrst_instret", o_instret, 64'd0);
      @(posedge i_clk);
      #1;
      chk("midrst_hold_wren", {63'd0, o_rd_wren}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
